controle_matriz: RTL and testbench
==================================

# controle_matriz

Command-driven sequencer for the 8-bit signed matrix datapath (2x2 to 5x5, row-major, 200-bit packed). It accepts one operation per valid/ready handshake, reads operand elements one at a time from a byte-wide synchronous memory into packed matrix registers, and evaluates the operation with the existing `oposicao_matriz` unit or inline element-wise add/subtract. It writes the result back element by element and signals completion. It sits between the system bus/command source and the combinational matrix operation units.

## Interface
- No parameters. Element width is 8 bits, capacity is 25 elements and the packed width is 200 bits, all fixed by the datapath.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller idle and able to accept a command.
- `cmd_op`  in  2  operation code: 00 oposicao (unary), 01 soma, 10 subtracao, 11 reserved (illegal).
- `cmd_size`  in  2  matrix size: 00 = 2x2, 01 = 3x3, 10 = 4x4, 11 = 5x5. Element count N = (cmd_size+2)².
- `cmd_base_a`, `cmd_base_b`, `cmd_base_r`  in  8 each  memory base addresses for operand A, operand B and the result.
- `mem_addr`  out  8  memory address.
- `mem_rd_en`  out  1  read strobe. Data returns on `mem_rdata` exactly 1 cycle later.
- `mem_rdata`  in  8  read data.
- `mem_wr_en`  out  1  write strobe.
- `mem_wdata`  out  8  write data.
- `resultado`  out  200  packed result. Held until the next command is accepted.
- `done`  out  1  one-cycle completion pulse.
- `erro`  out  1  valid only while `done` is high. Set to 1 for an illegal opcode.

## Operation
- States: OCIOSO, LE_A, LE_B, CALCULA, ESCREVE, FIM.
- OCIOSO:
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`, latch op, size and the three bases.
  - Clear matrix_A, matrix_B and `resultado` to 0.
  - Go to LE_A. For op 11, go to FIM with `erro` = 1 instead.
- LE_A lasts N+1 cycles, driven by element counter j.
  - In cycle j (0..N-1): `mem_rd_en` = 1, `mem_addr` = base_a + j (mod 256).
  - In cycle j+1: capture `mem_rdata` into matrix_A[j*8 +: 8].
  - In cycle N: no read is issued; capture the last element.
  - Next state is LE_B for soma/subtracao, otherwise CALCULA.
- LE_B: identical to LE_A, using base_b and matrix_B.
- CALCULA (1 cycle): register `resultado`.
  - oposicao: output of the `oposicao_matriz` instance (`matrix_size` = latched size).
  - soma: A+B per element.
  - subtracao: A−B per element.
  - All arithmetic is 8-bit two's complement with wrap. No saturation and no flags.
- ESCREVE (N cycles): in cycle j, `mem_wr_en` = 1, `mem_addr` = base_r + j (mod 256), `mem_wdata` = `resultado`[j*8 +: 8].
- FIM (1 cycle): `done` = 1, `erro` as latched. Then return to OCIOSO.
- Elements at index ≥ N stay 0 in matrix_A, matrix_B and `resultado`.
- `cmd_valid` while busy: `cmd_ready` = 0, so the command is not accepted and has no effect.
- Command inputs are sampled only at acceptance. Changes during an operation are ignored.
- Read and write are never asserted in the same cycle. Read and write address ranges may overlap; reads always complete before the first write.

## Timing
- Reset values: `cmd_ready` = 1, `mem_rd_en` = 0, `mem_wr_en` = 0, `mem_addr` = 0, `mem_wdata` = 0, `resultado` = 0, `done` = 0, `erro` = 0, state = OCIOSO, counter = 0.
- Reset asserted mid-operation aborts immediately. No further strobes are issued, and the memory holds whatever was already written.
- Cycle 0 is the acceptance edge. `done` is high in cycle L after it:
  - unary: L = (N+1) + 1 + N + 1 = 2N+3
  - binary: L = 2(N+1) + 1 + N + 1 = 3N+4
  - illegal op: L = 1
- Example: 2x2 oposicao gives L = 11. 5x5 soma gives L = 79.
- `cmd_ready` falls in the cycle after acceptance and rises in the cycle after `done`. Back-to-back commands are therefore separated by at least one idle cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `matriz_pkg`:
  - constants `ELEM_W` = 8, `MAX_ELEM` = 25, `MAT_W` = 200
  - opcode constants `OP_OPOSICAO`, `OP_SOMA`, `OP_SUBTRACAO`
  - state enum
  - function mapping size code to N
- Sub-module `contador_elementos`: a 5-bit element counter with clear, enable and `ultimo` (j == N−1) output, reused by LE_A, LE_B and ESCREVE.
- Instantiate the existing `oposicao_matriz`. Soma and subtracao are inline generate loops.

## Test plan
- 2x2 oposicao, base_a = 0x10, base_r = 0x40, memory {10, −20, 30, −40}:
  - writes {−10, 20, −30, 40} to 0x40..0x43
  - `done` at cycle 11 with `erro` = 0
  - `resultado` upper 168 bits = 0
- 5x5 soma, A[i] = i, B[i] = −2i: result[i] = −i. Wrap case: A[0] = 127, B[0] = 1 gives −128. `done` at cycle 79.
- 3x3 subtracao with base_a = 0xFC: read addresses wrap 0xFC..0xFF, 0x00..0x04. A[i] − B[i] is correct, including −128 − 1 = 127.
- Illegal op 11: no `mem_rd_en` or `mem_wr_en` ever asserted. `done` = 1 and `erro` = 1 at cycle 1. `cmd_ready` returns the following cycle.
- `cmd_valid` held high throughout a 4x4 oposicao: the second command is accepted only after `cmd_ready` returns, and produces its own full sequence.
- `rst_n` pulsed low during ESCREVE of a 4x4: write strobes stop immediately, all outputs are at reset values, and a new command afterwards completes normally.

Source files
------------

// File: rtl/matriz_pkg.sv
// Shared constants, opcodes, state encoding and helpers for the 8-bit signed matrix datapath.
package matriz_pkg;

    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned MAX_ELEM = 25;
    localparam int unsigned MAT_W    = ELEM_W * MAX_ELEM;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned ADDR_W   = 8;

    localparam logic [1:0] OP_OPOSICAO  = 2'b00;
    localparam logic [1:0] OP_SOMA      = 2'b01;
    localparam logic [1:0] OP_SUBTRACAO = 2'b10;
    localparam logic [1:0] OP_ILEGAL    = 2'b11;

    typedef enum logic [2:0] {
        OCIOSO,
        LE_A,
        LE_B,
        CALCULA,
        ESCREVE,
        FIM
    } estado_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [1:0]        size;
        logic [ADDR_W-1:0] base_a;
        logic [ADDR_W-1:0] base_b;
        logic [ADDR_W-1:0] base_r;
    } cmd_t;

    // Element count N = (size+2)^2 for the 2-bit size code.
    function automatic logic [CNT_W-1:0] n_elem(input logic [1:0] size);
        logic [CNT_W-1:0] n;
        case (size)
            2'b00:   n = 5'd4;
            2'b01:   n = 5'd9;
            2'b10:   n = 5'd16;
            default: n = 5'd25;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/controle_matriz_if.sv
// Command, memory and result bundle between the command source/memory and the matrix sequencer.
interface controle_matriz_if;

    logic                                  cmd_valid;
    logic                                  cmd_ready;
    logic [1:0]                            cmd_op;
    logic [1:0]                            cmd_size;
    logic [matriz_pkg::ADDR_W-1:0]         cmd_base_a;
    logic [matriz_pkg::ADDR_W-1:0]         cmd_base_b;
    logic [matriz_pkg::ADDR_W-1:0]         cmd_base_r;
    logic [matriz_pkg::ADDR_W-1:0]         mem_addr;
    logic                                  mem_rd_en;
    logic [matriz_pkg::ELEM_W-1:0]         mem_rdata;
    logic                                  mem_wr_en;
    logic [matriz_pkg::ELEM_W-1:0]         mem_wdata;
    logic [matriz_pkg::MAT_W-1:0]          resultado;
    logic                                  done;
    logic                                  erro;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_size, cmd_base_a, cmd_base_b, cmd_base_r, mem_rdata,
        output cmd_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, resultado, done, erro
    );

    // Command source and memory side.
    modport master (
        output cmd_valid, cmd_op, cmd_size, cmd_base_a, cmd_base_b, cmd_base_r, mem_rdata,
        input  cmd_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, resultado, done, erro
    );

endinterface

// File: rtl/contador_elementos.sv
// Element index counter shared by the read and write phases; ultimo flags index N-1.
module contador_elementos
    import matriz_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] n,
    output logic [CNT_W-1:0] cnt,
    output logic             ultimo
);

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + 5'd1;
        end
    end

    // ultimo is registered together with the count so it matches the current index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            ultimo <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            ultimo <= (cnt_nxt == (n - 5'd1));
        end
    end

endmodule

// File: rtl/oposicao_matriz.sv
// Element-wise two's complement negation of a packed matrix; elements beyond N forced to 0.
module oposicao_matriz
    import matriz_pkg::*;
(
    input  logic [1:0]       matrix_size,
    input  logic [MAT_W-1:0] matrix_in,
    output logic [MAT_W-1:0] matrix_out
);

    logic [CNT_W-1:0] n;

    assign n = n_elem(matrix_size);

    for (genvar i = 0; i < MAX_ELEM; i++) begin : g_elem
        assign matrix_out[i*ELEM_W +: ELEM_W] = (5'(i) < n)
            ? ({ELEM_W{1'b0}} - matrix_in[i*ELEM_W +: ELEM_W])
            : {ELEM_W{1'b0}};
    end

endmodule

// File: rtl/controle_matriz.sv
// Command-driven sequencer: loads operands element by element, evaluates the matrix
// operation, writes the result back and pulses done.
module controle_matriz
    import matriz_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    controle_matriz_if.slave bus
);

    estado_t            estado_q, estado_nxt;
    cmd_t               cmd_q, cmd_in;
    logic [MAT_W-1:0]   matrix_a_q, matrix_b_q, resultado_q;
    logic [MAT_W-1:0]   res_opos, res_soma, res_sub, res_calc;

    logic               ready_q, ready_nxt;
    logic               rd_q, rd_nxt;
    logic               wr_q, wr_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [ELEM_W-1:0]  wdata_q, wdata_nxt;
    logic               done_q, done_nxt;
    logic               erro_q, erro_nxt;

    logic               aceita;
    logic               cnt_clr, cnt_en;
    logic [CNT_W-1:0]   cnt, n_atual, idx_prox, cap_idx;
    logic               ultimo, fim_leitura;
    logic [ADDR_W-1:0]  base_le;

    assign cmd_in = '{op:     bus.cmd_op,
                      size:   bus.cmd_size,
                      base_a: bus.cmd_base_a,
                      base_b: bus.cmd_base_b,
                      base_r: bus.cmd_base_r};

    assign n_atual     = n_elem(cmd_q.size);
    assign idx_prox    = cnt + 5'd1;
    assign cap_idx     = cnt - 5'd1;
    assign fim_leitura = (cnt == n_atual);
    assign base_le     = (estado_q == LE_A) ? cmd_q.base_a : cmd_q.base_b;

    contador_elementos u_contador (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .n      (n_atual),
        .cnt    (cnt),
        .ultimo (ultimo)
    );

    oposicao_matriz u_oposicao (
        .matrix_size (cmd_q.size),
        .matrix_in   (matrix_a_q),
        .matrix_out  (res_opos)
    );

    for (genvar i = 0; i < MAX_ELEM; i++) begin : g_arit
        assign res_soma[i*ELEM_W +: ELEM_W] = matrix_a_q[i*ELEM_W +: ELEM_W] + matrix_b_q[i*ELEM_W +: ELEM_W];
        assign res_sub[i*ELEM_W +: ELEM_W]  = matrix_a_q[i*ELEM_W +: ELEM_W] - matrix_b_q[i*ELEM_W +: ELEM_W];
    end

    always_comb begin
        case (cmd_q.op)
            OP_SOMA:      res_calc = res_soma;
            OP_SUBTRACAO: res_calc = res_sub;
            default:      res_calc = res_opos;
        endcase
    end

    // Next state plus the value every registered output takes in the next cycle.
    always_comb begin
        estado_nxt = estado_q;
        ready_nxt  = 1'b0;
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        done_nxt   = 1'b0;
        erro_nxt   = 1'b0;
        aceita     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (estado_q)
            OCIOSO: begin
                ready_nxt = 1'b1;
                cnt_clr   = 1'b1;
                if (bus.cmd_valid && ready_q) begin
                    aceita    = 1'b1;
                    ready_nxt = 1'b0;
                    if (bus.cmd_op == OP_ILEGAL) begin
                        estado_nxt = FIM;
                        done_nxt   = 1'b1;
                        erro_nxt   = 1'b1;
                    end else begin
                        estado_nxt = LE_A;
                        rd_nxt     = 1'b1;
                        addr_nxt   = bus.cmd_base_a;
                    end
                end
            end

            LE_A, LE_B: begin
                if (fim_leitura) begin
                    cnt_clr = 1'b1;
                    if (estado_q == LE_A && cmd_q.op != OP_OPOSICAO) begin
                        estado_nxt = LE_B;
                        rd_nxt     = 1'b1;
                        addr_nxt   = cmd_q.base_b;
                    end else begin
                        estado_nxt = CALCULA;
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (!ultimo) begin
                        rd_nxt   = 1'b1;
                        addr_nxt = base_le + 8'(idx_prox);
                    end
                end
            end

            CALCULA: begin
                estado_nxt = ESCREVE;
                cnt_clr    = 1'b1;
                wr_nxt     = 1'b1;
                addr_nxt   = cmd_q.base_r;
                wdata_nxt  = res_calc[ELEM_W-1:0];
            end

            ESCREVE: begin
                if (ultimo) begin
                    estado_nxt = FIM;
                    cnt_clr    = 1'b1;
                    done_nxt   = 1'b1;
                end else begin
                    cnt_en    = 1'b1;
                    wr_nxt    = 1'b1;
                    addr_nxt  = cmd_q.base_r + 8'(idx_prox);
                    wdata_nxt = resultado_q[{idx_prox, 3'b000} +: ELEM_W];
                end
            end

            FIM: begin
                estado_nxt = OCIOSO;
                ready_nxt  = 1'b1;
                cnt_clr    = 1'b1;
            end

            default: begin
                estado_nxt = OCIOSO;
                ready_nxt  = 1'b1;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            ready_q  <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_nxt;
            ready_q  <= ready_nxt;
            rd_q     <= rd_nxt;
            wr_q     <= wr_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            done_q   <= done_nxt;
            erro_q   <= erro_nxt;
        end
    end

    // Operand capture lags the read strobe by one cycle, hence index cnt-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            matrix_a_q  <= '0;
            matrix_b_q  <= '0;
            resultado_q <= '0;
        end else begin
            if (aceita) begin
                cmd_q       <= cmd_in;
                matrix_a_q  <= '0;
                matrix_b_q  <= '0;
                resultado_q <= '0;
            end
            if (estado_q == LE_A && cnt != 5'd0) begin
                matrix_a_q[{cap_idx, 3'b000} +: ELEM_W] <= bus.mem_rdata;
            end
            if (estado_q == LE_B && cnt != 5'd0) begin
                matrix_b_q[{cap_idx, 3'b000} +: ELEM_W] <= bus.mem_rdata;
            end
            if (estado_q == CALCULA) begin
                resultado_q <= res_calc;
            end
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.mem_rd_en = rd_q;
    assign bus.mem_wr_en = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.resultado = resultado_q;
    assign bus.done      = done_q;
    assign bus.erro      = erro_q;

endmodule

// File: tb/tb_controle_matriz.sv
// Directed bench for controle_matriz with a byte-wide synchronous memory model.
module tb_controle_matriz;
    import matriz_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    controle_matriz_if bus();

    controle_matriz dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    int         cyc = 0;
    int         rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [7:0] rd_log [$];
    int         acc_log [$];
    int         done_log [$];
    int         n_cmp = 0, n_err = 0;

    // Memory with 1-cycle read latency, plus strobe/handshake monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_cnt <= rd_cnt + 1;
            rd_log.push_back(bus.mem_addr);
        end
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_rd_en && bus.mem_wr_en) both_cnt <= both_cnt + 1;
        if (bus.cmd_valid && bus.cmd_ready) acc_log.push_back(cyc + 1);
        if (bus.done) done_log.push_back(cyc + 1);
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] size,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_size = size;
        bus.cmd_base_a = a; bus.cmd_base_b = b; bus.cmd_base_r = r;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Returns the cycle index (1 = first cycle after acceptance) in which done is seen, -1 on timeout.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset cmd_ready: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset mem_rd_en: got %b want 0", bus.mem_rd_en); end
        n_cmp++; if (bus.mem_wr_en !== 1'b0) begin n_err++; $display("FAIL reset mem_wr_en: got %b want 0", bus.mem_wr_en); end
        n_cmp++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL reset mem_addr: got %h want 00", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 8'h00) begin n_err++; $display("FAIL reset mem_wdata: got %h want 00", bus.mem_wdata); end
        n_cmp++; if (bus.resultado !== 200'd0) begin n_err++; $display("FAIL reset resultado: got %h want 0", bus.resultado); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", bus.done); end
        n_cmp++; if (bus.erro !== 1'b0) begin n_err++; $display("FAIL reset erro: got %b want 0", bus.erro); end
    endtask

    task automatic test_oposicao_2x2();
        logic [7:0] exp_w [4] = '{8'hF6, 8'h14, 8'hE2, 8'h28};
        int lat, r0, w0, b0;
        poke(8'h10, 8'd10); poke(8'h11, 8'hEC); poke(8'h12, 8'd30); poke(8'h13, 8'hD8);
        r0 = rd_log.size(); w0 = wr_cnt; b0 = both_cnt;
        send_cmd(OP_OPOSICAO, 2'b00, 8'h10, 8'h00, 8'h40);
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL opos2 ready_after_accept: got %b want 0", bus.cmd_ready); end
        wait_done(100, lat);
        n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL opos2 latency: got %0d want 11", lat); end
        n_cmp++; if (bus.erro !== 1'b0) begin n_err++; $display("FAIL opos2 erro: got %b want 0", bus.erro); end
        n_cmp++; if (bus.resultado[31:0] !== 32'h28E214F6) begin n_err++; $display("FAIL opos2 resultado_low: got %h want 28e214f6", bus.resultado[31:0]); end
        n_cmp++; if (bus.resultado[199:32] !== 168'd0) begin n_err++; $display("FAIL opos2 resultado_high: got %h want 0", bus.resultado[199:32]); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[8'h40 + 8'(i)] !== exp_w[i]) begin n_err++; $display("FAIL opos2 mem[%0d]: got %h want %h", i, mem[8'h40 + 8'(i)], exp_w[i]); end
        end
        n_cmp++; if (rd_log.size() - r0 !== 4) begin n_err++; $display("FAIL opos2 read_count: got %0d want 4", rd_log.size() - r0); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_log[r0 + i] !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL opos2 rd_addr[%0d]: got %h want %h", i, rd_log[r0 + i], 8'h10 + 8'(i)); end
        end
        n_cmp++; if (wr_cnt - w0 !== 4) begin n_err++; $display("FAIL opos2 write_count: got %0d want 4", wr_cnt - w0); end
        @(posedge clk); #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL opos2 ready_return: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL opos2 done_width: got %b want 0", bus.done); end
        n_cmp++; if (both_cnt - b0 !== 0) begin n_err++; $display("FAIL opos2 rd_wr_overlap: got %0d want 0", both_cnt - b0); end
    endtask

    task automatic test_soma_5x5();
        int lat;
        logic [7:0] e;
        for (int i = 0; i < 25; i++) begin
            poke(8'(i), (i == 0) ? 8'd127 : 8'(i));
            poke(8'h20 + 8'(i), (i == 0) ? 8'd1 : 8'(-2 * i));
        end
        send_cmd(OP_SOMA, 2'b11, 8'h00, 8'h20, 8'h80);
        wait_done(200, lat);
        n_cmp++; if (lat !== 79) begin n_err++; $display("FAIL soma5 latency: got %0d want 79", lat); end
        n_cmp++; if (bus.erro !== 1'b0) begin n_err++; $display("FAIL soma5 erro: got %b want 0", bus.erro); end
        for (int i = 0; i < 25; i++) begin
            e = (i == 0) ? 8'h80 : 8'(-i);
            n_cmp++; if (bus.resultado[i*8 +: 8] !== e) begin n_err++; $display("FAIL soma5 resultado[%0d]: got %h want %h", i, bus.resultado[i*8 +: 8], e); end
            n_cmp++; if (mem[8'h80 + 8'(i)] !== e) begin n_err++; $display("FAIL soma5 mem[%0d]: got %h want %h", i, mem[8'h80 + 8'(i)], e); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_3x3_wrap();
        logic [7:0] a_v [9] = '{8'h80, 8'd5, 8'd100, 8'hCE, 8'd0, 8'd127, 8'hFF, 8'd20, 8'd7};
        logic [7:0] b_v [9] = '{8'd1, 8'd10, 8'h9C, 8'd50, 8'd0, 8'hFF, 8'd1, 8'hEC, 8'd7};
        logic [7:0] e_v [9] = '{8'h7F, 8'hFB, 8'hC8, 8'h9C, 8'h00, 8'h80, 8'hFE, 8'h28, 8'h00};
        logic [7:0] ra_v [9] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        int lat, r0;
        for (int i = 0; i < 9; i++) begin
            poke(ra_v[i], a_v[i]);
            poke(8'h50 + 8'(i), b_v[i]);
        end
        r0 = rd_log.size();
        send_cmd(OP_SUBTRACAO, 2'b01, 8'hFC, 8'h50, 8'hA0);
        wait_done(100, lat);
        n_cmp++; if (lat !== 31) begin n_err++; $display("FAIL sub3 latency: got %0d want 31", lat); end
        n_cmp++; if (bus.resultado[199:72] !== 128'd0) begin n_err++; $display("FAIL sub3 resultado_high: got %h want 0", bus.resultado[199:72]); end
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (mem[8'hA0 + 8'(i)] !== e_v[i]) begin n_err++; $display("FAIL sub3 mem[%0d]: got %h want %h", i, mem[8'hA0 + 8'(i)], e_v[i]); end
        end
        n_cmp++; if (rd_log.size() - r0 !== 18) begin n_err++; $display("FAIL sub3 read_count: got %0d want 18", rd_log.size() - r0); end
        else for (int i = 0; i < 9; i++) begin
            n_cmp++; if (rd_log[r0 + i] !== ra_v[i]) begin n_err++; $display("FAIL sub3 rd_addr_a[%0d]: got %h want %h", i, rd_log[r0 + i], ra_v[i]); end
            n_cmp++; if (rd_log[r0 + 9 + i] !== 8'h50 + 8'(i)) begin n_err++; $display("FAIL sub3 rd_addr_b[%0d]: got %h want %h", i, rd_log[r0 + 9 + i], 8'h50 + 8'(i)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ilegal();
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        send_cmd(OP_ILEGAL, 2'b11, 8'h00, 8'h00, 8'h00);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL ilegal done_cycle1: got %b want 1", bus.done); end
        n_cmp++; if (bus.erro !== 1'b1) begin n_err++; $display("FAIL ilegal erro: got %b want 1", bus.erro); end
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL ilegal ready_cycle1: got %b want 0", bus.cmd_ready); end
        n_cmp++; if (bus.resultado !== 200'd0) begin n_err++; $display("FAIL ilegal resultado_cleared: got %h want 0", bus.resultado); end
        @(posedge clk); #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL ilegal ready_cycle2: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL ilegal done_cycle2: got %b want 0", bus.done); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL ilegal reads: got %0d want 0", rd_cnt - r0); end
        n_cmp++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL ilegal writes: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_back_to_back();
        int a0, d0, r0, w0;
        for (int i = 0; i < 16; i++) poke(8'h60 + 8'(i), 8'(i + 1));
        a0 = acc_log.size(); d0 = done_log.size(); r0 = rd_cnt; w0 = wr_cnt;
        @(negedge clk);
        bus.cmd_op = OP_OPOSICAO; bus.cmd_size = 2'b10;
        bus.cmd_base_a = 8'h60; bus.cmd_base_b = 8'h00; bus.cmd_base_r = 8'hC0;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (done_log.size() - d0 >= 2) break;
        end
        @(negedge clk) bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (acc_log.size() - a0 !== 2) begin n_err++; $display("FAIL b2b accept_count: got %0d want 2", acc_log.size() - a0); end
        n_cmp++; if (done_log.size() - d0 !== 2) begin n_err++; $display("FAIL b2b done_count: got %0d want 2", done_log.size() - d0); end
        else if (acc_log.size() - a0 >= 2) begin
            n_cmp++; if (done_log[d0] - acc_log[a0] !== 35) begin n_err++; $display("FAIL b2b latency1: got %0d want 35", done_log[d0] - acc_log[a0]); end
            n_cmp++; if (acc_log[a0 + 1] - acc_log[a0] !== 36) begin n_err++; $display("FAIL b2b accept_gap: got %0d want 36", acc_log[a0 + 1] - acc_log[a0]); end
            n_cmp++; if (done_log[d0 + 1] - acc_log[a0 + 1] !== 35) begin n_err++; $display("FAIL b2b latency2: got %0d want 35", done_log[d0 + 1] - acc_log[a0 + 1]); end
        end
        n_cmp++; if (rd_cnt - r0 !== 32) begin n_err++; $display("FAIL b2b reads: got %0d want 32", rd_cnt - r0); end
        n_cmp++; if (wr_cnt - w0 !== 32) begin n_err++; $display("FAIL b2b writes: got %0d want 32", wr_cnt - w0); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (mem[8'hC0 + 8'(i)] !== 8'(-(i + 1))) begin n_err++; $display("FAIL b2b mem[%0d]: got %h want %h", i, mem[8'hC0 + 8'(i)], 8'(-(i + 1))); end
        end
    endtask

    task automatic test_reset_mid();
        int w0, lat;
        for (int i = 0; i < 16; i++) poke(8'hE0 + 8'(i), 8'hEE);
        w0 = wr_cnt;
        send_cmd(OP_OPOSICAO, 2'b10, 8'h60, 8'h00, 8'hE0);
        for (int c = 0; c < 100; c++) begin
            if (wr_cnt - w0 >= 5) break;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid mem_wr_en: got %b want 0", bus.mem_wr_en); end
        n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_err++; $display("FAIL rstmid mem_rd_en: got %b want 0", bus.mem_rd_en); end
        n_cmp++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL rstmid mem_addr: got %h want 00", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 8'h00) begin n_err++; $display("FAIL rstmid mem_wdata: got %h want 00", bus.mem_wdata); end
        n_cmp++; if (bus.resultado !== 200'd0) begin n_err++; $display("FAIL rstmid resultado: got %h want 0", bus.resultado); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rstmid cmd_ready: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.done !== 1'b0 || bus.erro !== 1'b0) begin n_err++; $display("FAIL rstmid done_erro: got %b%b want 00", bus.done, bus.erro); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (wr_cnt - w0 !== 5) begin n_err++; $display("FAIL rstmid writes: got %0d want 5", wr_cnt - w0); end
        n_cmp++; if (mem[8'hE4] !== 8'hFB) begin n_err++; $display("FAIL rstmid mem_e4: got %h want fb", mem[8'hE4]); end
        n_cmp++; if (mem[8'hE5] !== 8'hEE) begin n_err++; $display("FAIL rstmid mem_e5: got %h want ee", mem[8'hE5]); end
        send_cmd(OP_OPOSICAO, 2'b00, 8'h60, 8'h00, 8'hF0);
        wait_done(100, lat);
        n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL rstmid new_latency: got %0d want 11", lat); end
        n_cmp++; if (bus.resultado[31:0] !== 32'hFCFDFEFF) begin n_err++; $display("FAIL rstmid new_result: got %h want fcfdfeff", bus.resultado[31:0]); end
        n_cmp++; if (mem[8'hF3] !== 8'hFC) begin n_err++; $display("FAIL rstmid new_mem: got %h want fc", mem[8'hF3]); end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_size = '0;
        bus.cmd_base_a = '0; bus.cmd_base_b = '0; bus.cmd_base_r = '0;
        test_reset();
        test_oposicao_2x2();
        test_soma_5x5();
        test_sub_3x3_wrap();
        test_ilegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
